// File: rtl/key_debounce_ctrl_if.sv
// Key and marquee-control bundle between the push-button side and key_debounce_ctrl.
// The slave modport is the debouncer; the master modport drives the raw keys and watches the outputs.
interface key_debounce_ctrl_if;
  logic [1:0] key_n;
  logic [1:0] key_level;
  logic [1:0] key_pulse;
  logic [3:0] speed_sel;
  logic       dir;

  modport master (
    output key_n,
    input  key_level,
    input  key_pulse,
    input  speed_sel,
    input  dir
  );

  modport slave (
    input  key_n,
    output key_level,
    output key_pulse,
    output speed_sel,
    output dir
  );
endinterface

// File: rtl/key_debounce_ctrl.sv
// Two-key push-button debouncer driving the speed index and direction of a marquee.
// Each key is synchronized, debounced by its own four-state checker, and turned into one pulse per accepted press.
module key_debounce_ctrl #(
  parameter int DEB_CYCLES  = 4_000_000,
  parameter int SPEED_STEPS = 4
) (
  input logic                clk,
  input logic                rst_n,
  key_debounce_ctrl_if.slave kif
);

  localparam int               CNT_W      = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEB_CYCLES - 1);
  localparam logic [3:0]       SPEED_LAST = 4'(SPEED_STEPS - 1);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_PRESS_CHK = 2'd1;
  localparam logic [1:0] ST_PRESSED   = 2'd2;
  localparam logic [1:0] ST_REL_CHK   = 2'd3;

  logic [1:0]       sync_q1;
  logic [1:0]       sync_q2;
  logic [1:0]       state_q [2];
  logic [1:0]       state_d [2];
  logic [CNT_W-1:0] cnt_q   [2];
  logic [CNT_W-1:0] cnt_d   [2];
  logic [1:0]       level_d;
  logic [1:0]       pulse_d;
  logic [1:0]       level_q;
  logic [1:0]       pulse_q;
  logic [3:0]       speed_q;
  logic             dir_q;

  // Raw keys reset to the released level so a held key is re-qualified after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q1 <= 2'b11;
      sync_q2 <= 2'b11;
    end else begin
      sync_q1 <= kif.key_n;
      sync_q2 <= sync_q1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 2'b00;
    level_d = 2'b00;
    for (int k = 0; k < 2; k++) begin
      case (state_q[k])
        ST_IDLE: begin
          if (!sync_q2[k]) begin
            state_d[k] = ST_PRESS_CHK;
            cnt_d[k]   = '0;
          end
        end
        ST_PRESS_CHK: begin
          if (sync_q2[k]) begin
            state_d[k] = ST_IDLE;
            cnt_d[k]   = '0;
          end else if (cnt_q[k] == CNT_LAST) begin
            state_d[k] = ST_PRESSED;
            cnt_d[k]   = '0;
            pulse_d[k] = 1'b1;
          end else begin
            cnt_d[k] = cnt_q[k] + 1'b1;
          end
        end
        ST_PRESSED: begin
          if (sync_q2[k]) begin
            state_d[k] = ST_REL_CHK;
            cnt_d[k]   = '0;
          end
        end
        ST_REL_CHK: begin
          // Release is qualified the same way as a press, but never pulses.
          if (!sync_q2[k]) begin
            state_d[k] = ST_PRESSED;
            cnt_d[k]   = '0;
          end else if (cnt_q[k] == CNT_LAST) begin
            state_d[k] = ST_IDLE;
            cnt_d[k]   = '0;
          end else begin
            cnt_d[k] = cnt_q[k] + 1'b1;
          end
        end
        default: begin
          state_d[k] = ST_IDLE;
          cnt_d[k]   = '0;
        end
      endcase
      level_d[k] = (state_d[k] == ST_PRESSED) || (state_d[k] == ST_REL_CHK);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        state_q[k] <= ST_IDLE;
        cnt_q[k]   <= '0;
      end
      level_q <= 2'b00;
      pulse_q <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  // Registered pulses act one edge later; both keys may act on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      speed_q <= 4'd0;
      dir_q   <= 1'b0;
    end else begin
      if (pulse_q[0]) begin
        speed_q <= (speed_q >= SPEED_LAST) ? 4'd0 : speed_q + 4'd1;
      end
      if (pulse_q[1]) begin
        dir_q <= ~dir_q;
      end
    end
  end

  assign kif.key_level = level_q;
  assign kif.key_pulse = pulse_q;
  assign kif.speed_sel = speed_q;
  assign kif.dir       = dir_q;

endmodule
